// File: rtl/cla.sv
// Two-level carry-lookahead adder with registered sum and carry-out.
// 4-bit groups feed 16-bit super-groups, which are combined at the top.
module cla #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NG = WIDTH / GROUP;
    localparam int NS = NG / 4;

    // Carries into positions 1..3 of a 4-wide block, flat sum-of-products.
    function automatic logic [2:0] carries(
        input logic [3:0] pp,
        input logic [3:0] gg,
        input logic       ci
    );
        logic [2:0] c;
        c[0] = gg[0] | (pp[0] & ci);
        c[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        c[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
             | (pp[2] & pp[1] & pp[0] & ci);
        return c;
    endfunction

    // Block generate: carry produced inside the block regardless of carry-in.
    function automatic logic blkgen(
        input logic [3:0] pp,
        input logic [3:0] gg
    );
        return gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
             | (pp[3] & pp[2] & pp[1] & gg[0]);
    endfunction

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gc;
    logic [NS-1:0]    sp;
    logic [NS-1:0]    sg;
    logic [NS:0]      sc;

    assign p = A ^ B;
    assign g = A & B;

    // Level 1: bit carries inside each group, plus group propagate/generate.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        assign gp[gi] = &p[4*gi +: 4];
        assign gg[gi] = blkgen(p[4*gi +: 4], g[4*gi +: 4]);
        assign c[4*gi] = gc[gi];
        assign c[4*gi+1 +: 3] = carries(p[4*gi +: 4], g[4*gi +: 4], gc[gi]);
    end

    // Level 2: group carry-ins inside each super-group.
    for (genvar si = 0; si < NS; si++) begin : g_sup
        assign sp[si] = &gp[4*si +: 4];
        assign sg[si] = blkgen(gp[4*si +: 4], gg[4*si +: 4]);
        assign gc[4*si] = sc[si];
        assign gc[4*si+1 +: 3] = carries(gp[4*si +: 4], gg[4*si +: 4], sc[si]);
    end

    // Top level: each super-group carry-in as a flat sum-of-products over Cin.
    always_comb begin
        logic acc;
        logic prod;
        sc = '0;
        sc[0] = Cin;
        for (int k = 0; k < NS; k++) begin
            acc = 1'b0;
            for (int j = 0; j <= k; j++) begin
                prod = sg[j];
                for (int m = j + 1; m <= k; m++) begin
                    prod = prod & sp[m];
                end
                acc = acc | prod;
            end
            prod = Cin;
            for (int m = 0; m <= k; m++) begin
                prod = prod & sp[m];
            end
            sc[k+1] = acc | prod;
        end
    end

    assign sum = p ^ c;

    // Output register: capture sum and carry-out, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= sum;
            Cout <= sc[NS];
        end
    end

endmodule

// File: tb/tb_cla.sv
// Bench for cla: directed and random additions against a 33-bit
// arithmetic reference, checked by a queue-based monitor.
module tb_cla;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] S;
    logic        Cout;

    int total = 0;
    int bad   = 0;

    logic [32:0] expq[$];

    cla #(.WIDTH(32), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .S   (S),
        .Cout(Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] refsum(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        ci
    );
        return {1'b0, a} + {1'b0, b} + {32'd0, ci};
    endfunction

    task automatic check(input string name, input logic [32:0] act,
                         input logic [32:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got cout=%0b s=%08h want cout=%0b s=%08h",
                     name, act[32], act[31:0], req[32], req[31:0]);
        end
    endtask

    // Issue one addition at the falling edge and queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic ci);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = ci;
        expq.push_back(refsum(a, b, ci));
    endtask

    // Monitor: every edge with an outstanding issue must show its result.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("stream", {Cout, S}, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        A   = 32'h1234_5678;
        B   = 32'h0F0F_0F0F;
        Cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {Cout, S}, 33'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(32'h0000_0003, 32'h0000_0005, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h0000_ABCD, 32'h0000_1234, 1'b1);
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(32'h0000_0000, 32'h0000_0000, 1'b0);
        issue(32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && expq.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
            expq.delete();
        end

        // Asynchronous reset between edges with a nonzero result held.
        @(negedge clk);
        A   = 32'h0000_0003;
        B   = 32'h0000_0005;
        Cin = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset", {Cout, S}, 33'h0_0000_0008);
        A = 32'hFFFF_FFFF;
        B = 32'h0000_0001;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {Cout, S}, 33'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", {Cout, S}, 33'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", {Cout, S}, 33'h1_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
